// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Host-link front end for the processor. It takes a byte stream, writes it
// into instruction memory as big-endian 32-bit words, runs the processor for
// a host-chosen number of cycles, then streams the register file back out.
//
// Byte stream layout (big-endian, first byte = MSB):
//   WCNT[15:0]  number of program words that follow
//   RCYC[15:0]  number of cycles to hold `working` high
//   WCNT x 4 bytes of program words
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   in_data/in_valid/in_ready   host byte stream (transfer = valid & ready)
//   addr/wEn/wDat        instruction memory write port (one-cycle wEn pulses)
//   working              processor run enable
//   rID/rdata            register file read port (rdata combinational on rID)
//   out_data/out_idx/out_valid/out_ready   register dump stream
//   busy                 high in every state except header collection
//   err                  sticky header error (cleared only by reset)
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W = 9,
    parameter int NREGS  = 16,
    parameter int RID_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wEn,
    output logic [31:0]       wDat,
    output logic              working,
    output logic [RID_W-1:0]  rID,
    input  logic [31:0]       rdata,
    output logic [31:0]       out_data,
    output logic [RID_W-1:0]  out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_ERR
    } state_t;

    state_t            state;
    logic [1:0]        byte_cnt;    // bytes already collected in current group
    logic [23:0]       shift;       // first three bytes of header / word
    logic [15:0]       wcnt;
    logic [15:0]       rcyc;
    logic [15:0]       run_cnt;
    logic [ADDR_W-1:0] widx;
    logic              load_done;   // last write pulse is on the bus this cycle
    logic              dump_phase;  // 0: rID settling, 1: word presented

    logic        take;
    logic [31:0] full;
    logic [15:0] hdr_wcnt;
    logic [15:0] hdr_rcyc;
    logic        hdr_too_big;
    logic        last_word;

    assign take        = in_valid & in_ready;
    assign full        = {shift, in_data};
    assign hdr_wcnt    = full[31:16];
    assign hdr_rcyc    = full[15:0];
    assign hdr_too_big = 32'(hdr_wcnt) > (32'd1 << ADDR_W);
    assign last_word   = 32'(widx) == (32'(wcnt) - 32'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_HDR;
            in_ready   <= 1'b1;
            addr       <= '0;
            wEn        <= 1'b0;
            wDat       <= '0;
            working    <= 1'b0;
            rID        <= '0;
            out_data   <= '0;
            out_idx    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            byte_cnt   <= '0;
            shift      <= '0;
            wcnt       <= '0;
            rcyc       <= '0;
            run_cnt    <= '0;
            widx       <= '0;
            load_done  <= 1'b0;
            dump_phase <= 1'b0;
        end else begin
            wEn <= 1'b0;

            case (state)
                S_HDR: begin
                    if (take) begin
                        shift    <= full[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wcnt <= hdr_wcnt;
                            rcyc <= hdr_rcyc;
                            widx <= '0;
                            busy <= 1'b1;
                            if (hdr_too_big) begin
                                state    <= S_ERR;
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                            end else if (hdr_wcnt == 16'd0) begin
                                in_ready <= 1'b0;
                                if (hdr_rcyc == 16'd0) begin
                                    state      <= S_DUMP;
                                    rID        <= '0;
                                    dump_phase <= 1'b0;
                                end else begin
                                    state   <= S_RUN;
                                    working <= 1'b1;
                                    run_cnt <= hdr_rcyc;
                                end
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                end

                S_LOAD: begin
                    // The final write pulse gets its own cycle so wEn has
                    // already fallen when working rises.
                    if (load_done) begin
                        load_done <= 1'b0;
                        if (rcyc == 16'd0) begin
                            state      <= S_DUMP;
                            rID        <= '0;
                            dump_phase <= 1'b0;
                        end else begin
                            state   <= S_RUN;
                            working <= 1'b1;
                            run_cnt <= rcyc;
                        end
                    end else if (take) begin
                        shift    <= full[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wDat <= full;
                            addr <= widx;
                            wEn  <= 1'b1;
                            widx <= widx + 1'b1;
                            if (last_word) begin
                                load_done <= 1'b1;
                                in_ready  <= 1'b0;
                            end
                        end
                    end
                end

                S_RUN: begin
                    // working was raised on entry, so it stays high for the
                    // cycles in which run_cnt counts RCYC down to 1.
                    if (run_cnt == 16'd1) begin
                        working    <= 1'b0;
                        state      <= S_DUMP;
                        rID        <= '0;
                        dump_phase <= 1'b0;
                    end else begin
                        run_cnt <= run_cnt - 16'd1;
                    end
                end

                S_DUMP: begin
                    if (!dump_phase) begin
                        out_data   <= rdata;
                        out_idx    <= rID;
                        out_valid  <= 1'b1;
                        dump_phase <= 1'b1;
                    end else if (out_ready) begin
                        out_valid  <= 1'b0;
                        dump_phase <= 1'b0;
                        if (rID == RID_W'(NREGS - 1)) begin
                            state    <= S_HDR;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            rID      <= '0;
                        end else begin
                            rID <= rID + 1'b1;
                        end
                    end
                end

                S_ERR: begin
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                    busy     <= 1'b1;
                end

                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed sequence with randomized gaps, data and back-pressure. Expected
// writes, run pulses and dump words come from the program images and header
// fields the bench itself generates.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int ADDR_W = 9;
    localparam int NREGS  = 16;
    localparam int RID_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic              wEn;
    logic [31:0]       wDat;
    logic              working;
    logic [RID_W-1:0]  rID;
    logic [31:0]       rdata;
    logic [31:0]       out_data;
    logic [RID_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    always #10 clock = ~clock;

    // Register file stub.
    assign rdata = 32'hA000_0000 + 32'(rID);

    program_loader #(
        .ADDR_W(ADDR_W),
        .NREGS (NREGS),
        .RID_W (RID_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .addr     (addr),
        .wEn      (wEn),
        .wDat     (wDat),
        .working  (working),
        .rID      (rID),
        .rdata    (rdata),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .err      (err)
    );

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    int unsigned wr_addr_q[$];
    logic [31:0] wr_dat_q[$];
    int unsigned pulse_q[$];
    int unsigned run_len = 0;
    bit          overlap = 1'b0;

    // Passive observer: memory writes and working pulse lengths.
    always @(negedge clock) begin
        if (wEn === 1'b1) begin
            wr_addr_q.push_back(32'(addr));
            wr_dat_q.push_back(wDat);
            if (working === 1'b1) overlap = 1'b1;
        end
        if (working === 1'b1) begin
            run_len++;
        end else if (run_len != 0) begin
            pulse_q.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_monitors();
        wr_addr_q.delete();
        wr_dat_q.delete();
        pulse_q.delete();
        overlap   = 1'b0;
        stall_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned t;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 1000) begin
            stall_cnt++;
            step();
            t++;
        end
        if (t >= 1000) check32("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
    endtask

    task automatic send_header(input logic [15:0] wc, input logic [15:0] rc, input bit gaps);
        send_byte(wc[15:8], gaps);
        send_byte(wc[7:0], gaps);
        send_byte(rc[15:8], gaps);
        send_byte(rc[7:0], gaps);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[31:24], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[7:0], gaps);
    endtask

    task automatic collect_dump(input string tag, input int unsigned budget);
        int unsigned got = 0;
        int unsigned cyc = 0;
        bit pend = 1'b0;
        logic [31:0] pd = '0;
        logic [RID_W-1:0] pi = '0;
        while (got < NREGS && cyc < budget) begin
            out_ready = 1'($urandom_range(0, 1));
            #5;
            if (pend) begin
                check32({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check32({tag, "_hold_data"}, out_data, pd);
                check32({tag, "_hold_idx"}, 32'(out_idx), 32'(pi));
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    check32({tag, "_dump_idx"}, 32'(out_idx), got);
                    check32({tag, "_dump_data"}, out_data, 32'hA000_0000 + got);
                    got++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pd   = out_data;
                    pi   = out_idx;
                end
            end else begin
                pend = 1'b0;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check32({tag, "_dump_count"}, got, NREGS);
    endtask

    // Loads prog, runs for rc cycles and collects the dump, then compares
    // everything observed against what the header and program imply.
    task automatic run_program(input string tag, input logic [31:0] prog[$],
                               input logic [15:0] rc, input bit gaps);
        int unsigned n;
        int unsigned exp_pulses;
        clear_monitors();
        send_header(16'(prog.size()), rc, gaps);
        check32({tag, "_busy"}, 32'(busy), 32'd1);
        foreach (prog[i]) send_word(prog[i], gaps);
        in_valid = 1'b0;
        check32({tag, "_stalls"}, stall_cnt, 32'd0);
        collect_dump(tag, 32'(rc) + 400);
        check32({tag, "_wr_count"}, wr_addr_q.size(), prog.size());
        n = (wr_addr_q.size() < prog.size()) ? wr_addr_q.size() : prog.size();
        for (int unsigned i = 0; i < n; i++) begin
            check32({tag, "_wr_addr"}, wr_addr_q[i], i);
            check32({tag, "_wr_dat"}, wr_dat_q[i], prog[i]);
        end
        exp_pulses = (rc == 16'd0) ? 0 : 1;
        check32({tag, "_pulses"}, pulse_q.size(), exp_pulses);
        if (pulse_q.size() != 0 && exp_pulses != 0)
            check32({tag, "_run_len"}, pulse_q[0], 32'(rc));
        check32({tag, "_overlap"}, 32'(overlap), 32'd0);
        check32({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check32({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] p1[$];
        logic [31:0] pr[$];
        logic [15:0] rc;
        int unsigned nw;

        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #25;
        check32("rst_in_ready", 32'(in_ready), 32'd1);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        check32("rst_wen", 32'(wEn), 32'd0);
        check32("rst_working", 32'(working), 32'd0);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_addr", 32'(addr), 32'd0);
        check32("rst_wdat", wDat, 32'd0);
        check32("rst_rid", 32'(rID), 32'd0);
        check32("rst_out_data", out_data, 32'd0);
        check32("rst_out_idx", 32'(out_idx), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Reference program, back-to-back bytes, then with gaps.
        p1 = '{32'h10f00001, 32'h10f1000a, 32'h10f20014, 32'h10f3001e,
               32'h10f40028, 32'h10f50032, 32'h41000065, 32'h41100066,
               32'h41200067, 32'h40300065, 32'h40420066, 32'h40500067};
        run_program("t1", p1, 16'd20, 1'b0);
        run_program("t2", p1, 16'd20, 1'b1);

        // Random program, random run length.
        nw = $urandom_range(1, 20);
        pr.delete();
        for (int unsigned i = 0; i < nw; i++) pr.push_back($urandom);
        rc = 16'($urandom_range(1, 50));
        run_program("t3", pr, rc, 1'b1);

        // Empty header: dump starts straight after the header.
        clear_monitors();
        send_header(16'd0, 16'd0, 1'b0);
        in_valid = 1'b0;
        check32("t4_rid", 32'(rID), 32'd0);
        check32("t4_valid_settle", 32'(out_valid), 32'd0);
        check32("t4_busy", 32'(busy), 32'd1);
        check32("t4_in_ready", 32'(in_ready), 32'd0);
        step();
        check32("t4_valid_first", 32'(out_valid), 32'd1);
        check32("t4_data_first", out_data, 32'hA000_0000);
        collect_dump("t4", 400);
        check32("t4_no_writes", wr_addr_q.size(), 32'd0);
        check32("t4_no_pulse", pulse_q.size(), 32'd0);
        check32("t4_idle_busy", 32'(busy), 32'd0);

        // Second header after the empty one.
        pr.delete();
        pr.push_back($urandom);
        run_program("t4b", pr, 16'd3, 1'b0);

        // Largest legal program: 2^ADDR_W words.
        pr.delete();
        for (int unsigned i = 0; i < (1 << ADDR_W); i++) pr.push_back($urandom);
        run_program("t5", pr, 16'd1, 1'b0);

        // One word too many: sticky error.
        clear_monitors();
        send_header(16'h0201, 16'd5, 1'b0);
        check32("t6_err", 32'(err), 32'd1);
        check32("t6_in_ready", 32'(in_ready), 32'd0);
        check32("t6_busy", 32'(busy), 32'd1);
        in_data = 8'hAA;
        repeat (6) step();
        in_valid = 1'b0;
        check32("t6_err_hold", 32'(err), 32'd1);
        check32("t6_ready_hold", 32'(in_ready), 32'd0);
        check32("t6_no_writes", wr_addr_q.size(), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check32("t6_rst_err", 32'(err), 32'd0);
        check32("t6_rst_ready", 32'(in_ready), 32'd1);
        step();
        reset = 1'b0;
        step();

        // Reset in the fifth cycle of a 20-cycle run.
        clear_monitors();
        send_header(16'd0, 16'd20, 1'b0);
        in_valid = 1'b0;
        check32("t7_working_start", 32'(working), 32'd1);
        repeat (4) step();
        check32("t7_working_c5", 32'(working), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check32("t7_working_rst", 32'(working), 32'd0);
        check32("t7_busy_rst", 32'(busy), 32'd0);
        check32("t7_ready_rst", 32'(in_ready), 32'd1);
        step();
        reset = 1'b0;
        step();

        // Loader is usable again after the interrupted run.
        pr.delete();
        for (int unsigned i = 0; i < 3; i++) pr.push_back($urandom);
        run_program("t7b", pr, 16'd4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
